// File: rtl/var_delay_line_if.sv
// rtl/var_delay_line_if.sv - sample-stream and delay-control bundle for var_delay_line
interface var_delay_line_if #(
   parameter int WIDTH = 18,
   parameter int SEL_W = 3
);
   logic                    sam_clk_en;
   logic                    flush;
   logic signed [WIDTH-1:0] sig_in;
   logic [SEL_W-1:0]        delay_sel;
   logic                    delay_load;
   logic signed [WIDTH-1:0] sig_out;
   logic                    out_valid;
   logic                    delay_pending;
   logic [SEL_W-1:0]        active_delay;

   modport master (
      output sam_clk_en, flush, sig_in, delay_sel, delay_load,
      input  sig_out, out_valid, delay_pending, active_delay
   );

   modport slave (
      input  sam_clk_en, flush, sig_in, delay_sel, delay_load,
      output sig_out, out_valid, delay_pending, active_delay
   );
endinterface

// File: rtl/var_delay_line.sv
// rtl/var_delay_line.sv - sample-enable-gated delay line with runtime delay 0..MAX_DELAY
// Delay changes land only on sample boundaries; flush empties the line but keeps the programmed delay.
module var_delay_line #(
   parameter int WIDTH     = 18,
   parameter int MAX_DELAY = 6,
   parameter int SEL_W     = 3
) (
   input  logic            sys_clk,
   input  logic            reset,
   var_delay_line_if.slave bus
);
   localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DELAY);

   logic signed [WIDTH-1:0] d_q [1:MAX_DELAY];
   logic signed [WIDTH-1:0] d_d [1:MAX_DELAY];
   logic [SEL_W-1:0]        fill_q, fill_d;
   logic signed [WIDTH-1:0] sig_out_q, sig_out_d;
   logic                    out_valid_q, out_valid_d;
   logic [SEL_W-1:0]        active_q, active_d;
   logic [SEL_W-1:0]        pend_delay_q, pend_delay_d;
   logic                    pend_flag_q, pend_flag_d;

   logic [SEL_W-1:0]        req;
   logic [SEL_W-1:0]        eff_delay;
   logic signed [WIDTH-1:0] tap;
   logic                    advance;

   always_comb begin
      req       = (bus.delay_sel > MAX_SEL) ? MAX_SEL : bus.delay_sel;
      // A load coinciding with the enable takes effect immediately, bypassing the pending slot.
      eff_delay = bus.delay_load ? req : (pend_flag_q ? pend_delay_q : active_q);
      advance   = bus.sam_clk_en && !bus.flush;

      tap = bus.sig_in;
      for (int i = 1; i <= MAX_DELAY; i++) begin
         if (eff_delay == SEL_W'(i)) begin
            tap = d_q[i];
         end
      end
   end

   always_comb begin
      d_d          = d_q;
      fill_d       = fill_q;
      sig_out_d    = sig_out_q;
      out_valid_d  = out_valid_q;
      active_d     = active_q;
      pend_delay_d = pend_delay_q;
      pend_flag_d  = pend_flag_q;

      if (bus.flush) begin
         for (int i = 1; i <= MAX_DELAY; i++) begin
            d_d[i] = '0;
         end
         fill_d      = '0;
         sig_out_d   = '0;
         out_valid_d = 1'b0;
      end else if (bus.sam_clk_en) begin
         d_d[1] = bus.sig_in;
         for (int i = 2; i <= MAX_DELAY; i++) begin
            d_d[i] = d_q[i-1];
         end
         fill_d      = (fill_q == MAX_SEL) ? fill_q : fill_q + SEL_W'(1);
         sig_out_d   = tap;
         out_valid_d = (eff_delay == '0) || (fill_q >= eff_delay);
         active_d    = eff_delay;
         pend_flag_d = 1'b0;
      end

      // A flushed enable does not apply anything, so a load there stays pending.
      if (bus.delay_load) begin
         pend_delay_d = req;
         if (!advance) begin
            pend_flag_d = 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         for (int i = 1; i <= MAX_DELAY; i++) begin
            d_q[i] <= '0;
         end
         fill_q       <= '0;
         sig_out_q    <= '0;
         out_valid_q  <= 1'b0;
         active_q     <= '0;
         pend_delay_q <= '0;
         pend_flag_q  <= 1'b0;
      end else begin
         for (int i = 1; i <= MAX_DELAY; i++) begin
            d_q[i] <= d_d[i];
         end
         fill_q       <= fill_d;
         sig_out_q    <= sig_out_d;
         out_valid_q  <= out_valid_d;
         active_q     <= active_d;
         pend_delay_q <= pend_delay_d;
         pend_flag_q  <= pend_flag_d;
      end
   end

   assign bus.sig_out       = sig_out_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.delay_pending = pend_flag_q;
   assign bus.active_delay  = active_q;
endmodule

// File: tb/tb_var_delay_line.sv
// tb/tb_var_delay_line.sv - scoreboard bench for var_delay_line against a sample-history model
module tb_var_delay_line;
   localparam int WIDTH     = 18;
   localparam int MAX_DELAY = 6;
   localparam int SEL_W     = 3;

   typedef struct {
      logic signed [WIDTH-1:0] out;
      logic                    val;
      logic                    pend;
      logic [SEL_W-1:0]        act;
   } exp_t;

   logic sys_clk = 1'b0;
   logic reset   = 1'b1;

   var_delay_line_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) vif ();

   var_delay_line #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .SEL_W(SEL_W)) dut (
      .sys_clk (sys_clk),
      .reset   (reset),
      .bus     (vif.slave)
   );

   always #5 sys_clk = ~sys_clk;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Model: the line is just the list of samples accepted since the last flush/reset, newest first.
   logic signed [WIDTH-1:0] hist[$];
   int                      m_act = 0;
   int                      m_pend = 0;
   bit                      m_pflag = 0;
   logic signed [WIDTH-1:0] m_out = '0;
   bit                      m_val = 0;

   task automatic step(input bit r, input bit e, input bit f,
                       input logic signed [WIDTH-1:0] x, input int sel, input bit l);
      int   req;
      int   k;
      exp_t ex;
      @(negedge sys_clk);
      reset          = r;
      vif.sam_clk_en = e;
      vif.flush      = f;
      vif.sig_in     = x;
      vif.delay_sel  = SEL_W'(sel);
      vif.delay_load = l;

      req = (sel > MAX_DELAY) ? MAX_DELAY : sel;
      if (r) begin
         hist.delete();
         m_act = 0; m_pend = 0; m_pflag = 0; m_out = '0; m_val = 0;
      end else if (f) begin
         hist.delete();
         m_out = '0;
         m_val = 0;
         if (l) begin m_pend = req; m_pflag = 1; end
      end else if (e) begin
         k = l ? req : (m_pflag ? m_pend : m_act);
         if (k == 0)                m_out = x;
         else if (k <= hist.size()) m_out = hist[k-1];
         else                       m_out = '0;
         m_val   = (k == 0) || (hist.size() >= k);
         m_act   = k;
         m_pflag = 0;
         hist.push_front(x);
         if (hist.size() > MAX_DELAY) void'(hist.pop_back());
      end else if (l) begin
         m_pend  = req;
         m_pflag = 1;
      end

      ex.out  = m_out;
      ex.val  = m_val;
      ex.pend = m_pflag;
      ex.act  = SEL_W'(m_act);
      exp_q.push_back(ex);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0);
   endtask

   initial begin : monitor
      exp_t ex;
      forever begin
         @(posedge sys_clk);
         #1;
         if (exp_q.size() != 0) begin
            ex = exp_q.pop_front();
            n_checks += 4;
            if (vif.sig_out !== ex.out) begin
               n_errors++;
               $display("FAIL sig_out @%0t: got %0d required %0d", $time, vif.sig_out, ex.out);
            end
            if (vif.out_valid !== ex.val) begin
               n_errors++;
               $display("FAIL out_valid @%0t: got %0b required %0b", $time, vif.out_valid, ex.val);
            end
            if (vif.delay_pending !== ex.pend) begin
               n_errors++;
               $display("FAIL delay_pending @%0t: got %0b required %0b", $time, vif.delay_pending, ex.pend);
            end
            if (vif.active_delay !== ex.act) begin
               n_errors++;
               $display("FAIL active_delay @%0t: got %0d required %0d", $time, vif.active_delay, ex.act);
            end
         end
      end
   end

   initial begin : stimulus
      vif.sam_clk_en = 0; vif.flush = 0; vif.sig_in = '0; vif.delay_sel = '0; vif.delay_load = 0;

      // Reset state
      step(1, 0, 0, '0, 0, 0);
      step(1, 1, 1, 18'sd77, 5, 1);
      idle(2);

      // Fixed delay 3, enable every 4th cycle
      step(0, 0, 0, '0, 3, 1);
      for (int i = 1; i <= 10; i++) begin
         idle(3);
         step(0, 1, 0, WIDTH'(i), 0, 0);
      end
      idle(3);

      // Clamping: sel 7 -> 6
      step(1, 0, 0, '0, 0, 0);
      step(0, 0, 0, '0, 7, 1);
      for (int i = 1; i <= 9; i++) step(0, 1, 0, WIDTH'(i), 0, 0);
      idle(2);

      // Deferred change from 2 to 5 with a full line, including an overwritten load
      step(1, 0, 0, '0, 0, 0);
      step(0, 1, 0, 18'sd20, 2, 1);
      for (int i = 1; i <= 8; i++) step(0, 1, 0, WIDTH'(20 + i), 0, 0);
      step(0, 0, 0, '0, 1, 1);
      step(0, 0, 0, '0, 5, 1);
      idle(2);
      for (int i = 1; i <= 4; i++) step(0, 1, 0, WIDTH'(40 + i), 0, 0);

      // Coincident load sel 0 with enable
      step(0, 1, 0, -18'sd123, 0, 1);
      idle(2);
      step(0, 1, 0, 18'sd55, 0, 0);

      // Flush with enable at delay 4
      step(0, 0, 0, '0, 4, 1);
      for (int i = 1; i <= 6; i++) step(0, 1, 0, WIDTH'(60 + i), 0, 0);
      step(0, 1, 1, 18'sd999, 0, 0);
      for (int i = 1; i <= 6; i++) step(0, 1, 0, WIDTH'(70 + i), 0, 0);
      step(0, 1, 1, 18'sd998, 2, 1);
      for (int i = 1; i <= 4; i++) step(0, 1, 0, WIDTH'(80 + i), 0, 0);

      // Reset while pending with a full line
      step(0, 0, 0, '0, 3, 1);
      for (int i = 1; i <= 7; i++) step(0, 1, 0, WIDTH'(90 + i), 0, 0);
      step(0, 0, 0, '0, 5, 1);
      step(1, 1, 0, 18'sd500, 2, 1);
      step(0, 1, 0, 18'sd501, 0, 0);
      idle(2);

      // Randomised traffic
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 39) == 0),
              WIDTH'($urandom),
              $urandom_range(0, 7),
              ($urandom_range(0, 9) == 0));
      end
      idle(3);

      @(negedge sys_clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/var_delay_line.md
# var_delay_line

Parametrised, sample-enable-gated delay line with a runtime-selectable delay of 0..MAX_DELAY samples, registered output, and output-valid tracking. It sits in the sample-rate datapath between filter stages and aligns the timing of parallel branches (e.g. I/Q or matched-filter vs. bypass paths). Delay changes are requested with a load strobe and take effect only on a sample boundary, so the output never changes between sample enables. It also provides a synchronous flush that empties the line without losing the programmed delay.

## Interface
- WIDTH, 18, sample width in bits (signed two's complement).
- MAX_DELAY, 6, deepest tap in samples; must be ≥1.
- SEL_W, 3, width of delay_sel; must satisfy 2^SEL_W > MAX_DELAY.
- sys_clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset, sampled on sys_clk.
- sam_clk_en  in  1  one-sys_clk-wide sample enable; the line advances only when this is high.
- flush  in  1  synchronous clear of line contents; active-high.
- sig_in  in  WIDTH  signed input sample, valid when sam_clk_en is high.
- delay_sel  in  SEL_W  requested delay in samples, captured when delay_load is high.
- delay_load  in  1  single-cycle strobe that requests a delay change.
- sig_out  out  WIDTH  signed delayed sample; registered.
- out_valid  out  1  high when sig_out holds a real input sample rather than flush/reset fill.
- delay_pending  out  1  high from the cycle after a delay_load until the change is applied.
- active_delay  out  SEL_W  delay currently in effect; registered.

## Operation
- Storage: registers d[1..MAX_DELAY], each WIDTH wide. On sam_clk_en: d[1] <= sig_in and d[k] <= d[k-1]. Otherwise all registers hold. tap(0) = sig_in; tap(k) = d[k] (pre-shift value) for k ≥ 1.
- Delay request: on delay_load, capture req = min(delay_sel, MAX_DELAY) (clamped) into pending_delay and set delay_pending. A second load before the change is applied overwrites pending_delay; the last load wins.
- Delay apply: on a sam_clk_en cycle, the effective delay k is:
  - req, if delay_load is high in the same cycle (bypasses pending);
  - else pending_delay, if delay_pending is set;
  - else active_delay.
  On that cycle, active_delay <= k and delay_pending <= 0.
- Output: on sam_clk_en, sig_out <= tap(k) using the same k. Otherwise sig_out holds. No arithmetic is performed; samples pass through bit-exact.
- Fill tracking: fill_cnt counts 0..MAX_DELAY and saturates at MAX_DELAY. It is incremented on each sam_clk_en that is not flushed. On sam_clk_en, out_valid <= (k == 0) || (fill_cnt ≥ k), using the pre-increment fill_cnt.
- Increasing the delay past fill_cnt therefore drops out_valid until the line refills. Decreasing the delay keeps out_valid high; samples are skipped and none are repeated.
- Flush: clears d[*], fill_cnt, sig_out and out_valid to 0. It retains active_delay, pending_delay and delay_pending.
- Flush and sam_clk_en in the same cycle: flush wins and the sample is dropped. A delay_load in that cycle is still captured as pending, and is applied at the next enable.
- Reset: all registers go to 0, i.e. sig_out=0, out_valid=0, delay_pending=0, active_delay=0, fill_cnt=0. Reset overrides flush, load and enable.

## Timing
- Latency: a sample presented with enable n appears on sig_out one sys_clk after enable n+k. Delay 0 gives one sys_clk register latency and zero sample latency.
- sig_out, out_valid and active_delay change only in the cycle following a sam_clk_en, flush or reset edge.
- delay_pending asserts the cycle after delay_load, unless the load coincides with sam_clk_en, in which case it stays 0. It deasserts the cycle after the applying enable.
- Throughput: one sample per sam_clk_en. Back-to-back enables (sam_clk_en held high) are supported.
- Reset mid-stream: the outputs read 0 on the first cycle after reset is sampled.

## Test plan
- Fixed delay: reset, load delay_sel=3, feed 1,2,3,... with sam_clk_en every 4th cycle. Required: sig_out=1 after the 4th enable; out_valid is 0 for the first 3 enables and 1 thereafter; sig_out is stable between enables.
- Clamping: MAX_DELAY=6, load delay_sel=7. Required: active_delay=6, and sample 1 appears after the 7th enable.
- Deferred change: at delay 2 with the line full, pulse delay_load with sel=5 between enables. Required: delay_pending=1 until the next enable. Then active_delay=5 and out_valid=1 (fill_cnt=6 ≥ 5), with sig_out jumping back to the sample from 5 enables earlier.
- Coincident load and enable: load sel=0 on an enable cycle. Required: sig_out equals sig_in of that enable, and delay_pending never asserts.
- Flush: after 6 samples at delay 4, assert flush together with sam_clk_en. Required: sig_out=0, out_valid=0, active_delay stays 4, and the dropped sample never appears. out_valid returns after 4 further enables.
- Reset mid-operation: assert reset while delay_pending=1 and the line is full. Required: every output is 0 the next cycle, and the following enable passes sig_in at delay 0 with out_valid=1.
